vga_timing_rx: RTL and testbench
================================

# vga_timing_rx

Receive-side counterpart of the VGA output timing generator. Consumes a raw hsync/vsync/RGB stream produced on the same clock, locks to its frame structure, and reconstructs active-area pixel coordinates, a data-enable, and gated pixel data. Sits at the input of any block that re-samples or checks our video output, such as loopback self-test or frame capture.

## Interface
Parameters:
- H_TOTAL, 1681: clocks per line, from hsync fall to hsync fall.
- V_TOTAL, 829: lines per frame, from vsync rise to vsync rise.
- H_SYNC, 136: hsync low width in clocks.
- H_ACT_START, 336: first active h position.
- H_ACT, 1280: active pixels per line.
- V_ACT_START, 27: first active line.
- V_ACT, 800: active lines per frame.
- LOCK_FRAMES, 2: consecutive good frames needed to assert lock.

Ports:
- clk  in  1  pixel clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- hsync_in  in  1  active-low line sync, synchronous to clk.
- vsync_in  in  1  active-high frame sync, synchronous to clk.
- red_in, gre_in, blu_in  in  4 each  pixel data.
- red_out, gre_out, blu_out  out  4 each  pixel data, forced to 0 when de=0.
- curr_x  out  11  active x, 0..H_ACT-1; 0 when de=0.
- curr_y  out  10  active y, 0..V_ACT-1; 0 when de=0.
- de  out  1  active-area data enable.
- locked  out  1  timing lock status.
- frame_start  out  1  one-cycle pulse on the first output cycle of a frame (v_pos=0, h_pos=0) while locked.
- err  out  1  one-cycle pulse on any timing violation.

## Operation
- Stage 1 registers hsync_in, vsync_in and the RGB inputs. Edge detection uses stage 1 and its previous value.
  - Line edge: hsync goes 1→0.
  - Frame edge: vsync goes 0→1.
- h_pos (11b) gives the source h position of the sample in stage 1.
  - Cleared to 0 on a line edge; otherwise increments.
  - Saturates at 2047. Reaching 2047 is a violation.
- v_pos (10b) updates on each line edge.
  - Set to 0 if a frame edge occurs in the same cycle as the line edge, or since the previous line edge.
  - Otherwise increments, saturating at 1023. Reaching 1023 is a violation.
- Checks, each a violation on mismatch:
  - At each line edge, the completed line length (h_pos+1) must equal H_TOTAL.
  - At each frame edge, completed line count must equal V_TOTAL.
  - hsync must return high exactly at h_pos = H_SYNC.
- FSM:
  - SEARCH: locked=0. A frame edge moves to CHECK with good=0.
  - CHECK: each violation-free frame edge increments good. When good reaches LOCK_FRAMES, move to LOCKED. A violation returns to SEARCH.
  - LOCKED: locked=1. A violation pulses err, returns to SEARCH, and locked falls the next cycle.
- err pulses on violations in all states. In SEARCH, only the saturation violations apply.
- Output stage 2 (registered):
  - de = locked ∧ H_ACT_START ≤ h_pos < H_ACT_START+H_ACT ∧ V_ACT_START ≤ v_pos < V_ACT_START+V_ACT.
  - curr_x = h_pos−H_ACT_START and curr_y = v_pos−V_ACT_START, computed in 11/10-bit wrap arithmetic and muxed to 0 outside de.
  - RGB_out = stage-1 RGB when de, else 0.
- If a line edge and a saturation occur in the same cycle, the edge wins: the counter clears and no violation is raised for saturation.

## Timing
- Reset: all outputs 0, FSM=SEARCH, h_pos=v_pos=0, good=0, edge-history registers hold "hsync=1, vsync=0".
- Latency is 2 clocks from input pins to RGB_out/curr_x/curr_y/de, all mutually aligned.
- Lock from reset with clean input is asserted 2 clocks after the (LOCK_FRAMES+1)th frame edge at the pins.
- A reset mid-frame drops all outputs immediately (asynchronous). After release, the block resynchronises from SEARCH.
- With the default stream, de first rises for source hcount 336, vcount 27, with curr_x=0, curr_y=0. It is last high at curr_x=1279, curr_y=799.

## Configuration
- VGA_RX_ERR_CNT_EN defined: adds output err_count (8b), reset 0.
  - Increments on each err pulse and saturates at 255.
  - Cleared only by rst_n.
- VGA_RX_ERR_CNT_EN undefined: the port and the counter do not exist. All other behaviour is identical.

## Test plan
- Clean default stream from the output generator for 4 frames → locked rises 2 clocks after the 3rd vsync rise. frame_start pulses once per frame thereafter. err never pulses.
- Locked stream; compare per-pixel against the generator → de/curr_x/curr_y match the generator's active window delayed 2 clocks. 1280×800 de-high cycles per frame. RGB_out=0 outside de.
- One line shortened to 1680 clocks while locked → single err pulse, locked falls. Relock after 2 further clean frames. err_count=1 with macro.
- hsync held high for 3000 clocks → err at h_pos=2047, FSM in SEARCH, de=0.
- Frame with 830 lines → err at the frame edge, no lock gained from that frame.
- rst_n pulsed low mid-active-line → all outputs 0 within the same cycle. Lock regained after 3 frame edges.

Source files
------------

// File: rtl/vga_timing_rx.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_rx
// Purpose  : Locks to a raw hsync/vsync/RGB stream and rebuilds active-area
//            coordinates, data-enable and gated pixels. Define
//            VGA_RX_ERR_CNT_EN to add the saturating err_count output.
// Revision : 1.0
// ============================================================================
module vga_timing_rx #(
    parameter int H_TOTAL     = 1681,
    parameter int V_TOTAL     = 829,
    parameter int H_SYNC      = 136,
    parameter int H_ACT_START = 336,
    parameter int H_ACT       = 1280,
    parameter int V_ACT_START = 27,
    parameter int V_ACT       = 800,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [3:0]  red_in,
    input  logic [3:0]  gre_in,
    input  logic [3:0]  blu_in,
    output logic [3:0]  red_out,
    output logic [3:0]  gre_out,
    output logic [3:0]  blu_out,
    output logic [10:0] curr_x,
    output logic [9:0]  curr_y,
    output logic        de,
    output logic        locked,
    output logic        frame_start,
    output logic        err
`ifdef VGA_RX_ERR_CNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    localparam logic [11:0] c_h_total     = 12'(H_TOTAL);
    localparam logic [10:0] c_v_total     = 11'(V_TOTAL);
    localparam logic [10:0] c_h_sync      = 11'(H_SYNC);
    localparam logic [11:0] c_h_act_lo    = 12'(H_ACT_START);
    localparam logic [11:0] c_h_act_hi    = 12'(H_ACT_START + H_ACT);
    localparam logic [10:0] c_v_act_lo    = 11'(V_ACT_START);
    localparam logic [10:0] c_v_act_hi    = 11'(V_ACT_START + V_ACT);
    localparam logic [7:0]  c_lock_frames = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_CHECK  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_hs1, r_vs1, r_hs_prev, r_vs_prev, r_fpend;
    logic [11:0] r_rgb1;
    logic [10:0] r_hcnt, w_h_pos;
    logic [9:0]  r_vcnt, w_v_pos;
    logic [7:0]  r_good, w_good_nxt;
    logic        w_line_edge, w_frame_edge, w_hs_rise;
    logic        w_sat_h, w_sat_v, w_len_bad, w_cnt_bad, w_sync_bad;
    logic        w_viol, w_locked_nxt, w_h_in, w_v_in, w_de;

    assign w_line_edge  = r_hs_prev & ~r_hs1;
    assign w_frame_edge = ~r_vs_prev & r_vs1;
    assign w_hs_rise    = ~r_hs_prev & r_hs1;

    // Position of the stage-1 sample; a line edge always beats saturation.
    always_comb begin
        w_h_pos = r_hcnt;
        w_sat_h = 1'b0;
        w_v_pos = r_vcnt;
        w_sat_v = 1'b0;
        if (w_line_edge) begin
            w_h_pos = '0;
            if (w_frame_edge || r_fpend) begin
                w_v_pos = '0;
            end else if (r_vcnt != 10'h3FF) begin
                w_v_pos = r_vcnt + 10'd1;
                w_sat_v = (r_vcnt == 10'h3FE);
            end
        end else if (r_hcnt != 11'h7FF) begin
            w_h_pos = r_hcnt + 11'd1;
            w_sat_h = (r_hcnt == 11'h7FE);
        end
    end

    assign w_len_bad  = w_line_edge  & (({1'b0, r_hcnt} + 12'd1) != c_h_total);
    assign w_cnt_bad  = w_frame_edge & (({1'b0, r_vcnt} + 11'd1) != c_v_total);
    assign w_sync_bad = w_hs_rise ? (w_h_pos != c_h_sync)
                                  : ((w_h_pos == c_h_sync) & ~r_hs1);

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        w_viol      = w_sat_h | w_sat_v |
                      ((r_state != S_SEARCH) & (w_len_bad | w_cnt_bad | w_sync_bad));
        if (w_viol) begin
            w_state_nxt = S_SEARCH;
        end else if (w_frame_edge) begin
            unique case (r_state)
                S_SEARCH: begin
                    w_state_nxt = S_CHECK;
                    w_good_nxt  = '0;
                end
                S_CHECK: begin
                    w_good_nxt = r_good + 8'd1;
                    if (w_good_nxt == c_lock_frames) w_state_nxt = S_LOCKED;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Lock is taken from the next state so de and locked change together.
    assign w_locked_nxt = (w_state_nxt == S_LOCKED);
    assign w_h_in = ({1'b0, w_h_pos} >= c_h_act_lo) && ({1'b0, w_h_pos} < c_h_act_hi);
    assign w_v_in = ({1'b0, w_v_pos} >= c_v_act_lo) && ({1'b0, w_v_pos} < c_v_act_hi);
    assign w_de   = w_locked_nxt & w_h_in & w_v_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs1       <= 1'b1;
            r_vs1       <= 1'b0;
            r_rgb1      <= '0;
            r_hs_prev   <= 1'b1;
            r_vs_prev   <= 1'b0;
            r_hcnt      <= '0;
            r_vcnt      <= '0;
            r_fpend     <= 1'b0;
            r_good      <= '0;
            r_state     <= S_SEARCH;
            de          <= 1'b0;
            curr_x      <= '0;
            curr_y      <= '0;
            red_out     <= '0;
            gre_out     <= '0;
            blu_out     <= '0;
            locked      <= 1'b0;
            frame_start <= 1'b0;
            err         <= 1'b0;
        end else begin
            r_hs1       <= hsync_in;
            r_vs1       <= vsync_in;
            r_rgb1      <= {red_in, gre_in, blu_in};
            r_hs_prev   <= r_hs1;
            r_vs_prev   <= r_vs1;
            r_hcnt      <= w_h_pos;
            r_vcnt      <= w_v_pos;
            r_fpend     <= w_line_edge ? 1'b0 : (r_fpend | w_frame_edge);
            r_good      <= w_good_nxt;
            r_state     <= w_state_nxt;
            de          <= w_de;
            curr_x      <= w_de ? (w_h_pos - c_h_act_lo[10:0]) : '0;
            curr_y      <= w_de ? (w_v_pos - c_v_act_lo[9:0]) : '0;
            red_out     <= w_de ? r_rgb1[11:8] : '0;
            gre_out     <= w_de ? r_rgb1[7:4]  : '0;
            blu_out     <= w_de ? r_rgb1[3:0]  : '0;
            locked      <= w_locked_nxt;
            frame_start <= w_locked_nxt & (w_h_pos == '0) & (w_v_pos == '0);
            err         <= w_viol;
        end
    end

`ifdef VGA_RX_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (w_viol && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_rx
// Purpose  : Randomised bench for vga_timing_rx against a timestamp-based
//            reference model on a reduced video format.
// Revision : 1.0
// ============================================================================
module tb_vga_timing_rx;

    localparam int HT  = 40;
    localparam int HS  = 6;
    localparam int HAS = 10;
    localparam int HA  = 24;
    localparam int VT  = 20;
    localparam int VAS = 3;
    localparam int VA  = 12;
    localparam int LF  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b0;
    logic [3:0]  red_in = '0, gre_in = '0, blu_in = '0;
    logic [3:0]  red_out, gre_out, blu_out;
    logic [10:0] curr_x;
    logic [9:0]  curr_y;
    logic        de, locked, frame_start, err;
`ifdef VGA_RX_ERR_CNT_EN
    logic [7:0]  err_count;
`endif

    vga_timing_rx #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_SYNC(HS), .H_ACT_START(HAS), .H_ACT(HA),
        .V_ACT_START(VAS), .V_ACT(VA), .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .red_in(red_in), .gre_in(gre_in), .blu_in(blu_in),
        .red_out(red_out), .gre_out(gre_out), .blu_out(blu_out),
        .curr_x(curr_x), .curr_y(curr_y), .de(de), .locked(locked),
        .frame_start(frame_start), .err(err)
`ifdef VGA_RX_ERR_CNT_EN
        , .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int de_count = 0;
    int fs_count = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int de; int x; int y; int r; int g; int b; int lk; int fs; int er; int ec;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: positions measured as elapsed samples since sync events.
    localparam int M_SEARCH = 0, M_CHECK = 1, M_LOCKED = 2;
    int m_t, m_t_fall, m_lines, m_armed, m_st, m_good, m_errs, m_phs, m_pvs;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic void model_reset();
        m_t = 0; m_t_fall = -2; m_lines = 0; m_armed = 0;
        m_st = M_SEARCH; m_good = 0; m_errs = 0; m_phs = 1; m_pvs = 0;
    endfunction

    function automatic exp_t idle_exp();
        exp_t e;
        e = '{default: 0};
        e.ec = m_errs;
        return e;
    endfunction

    function automatic exp_t model_step(input int hs, input int vs, input int r, input int g, input int b);
        exp_t e;
        int le, fe, rise, age, h, v, sat, bad, viol, lk;
        le = (m_phs == 1 && hs == 0); fe = (m_pvs == 0 && vs == 1); rise = (m_phs == 0 && hs == 1);
        age = m_t - m_t_fall;
        sat = 0; bad = 0;
        if (fe && imin(m_lines, 1023) + 1 != VT) bad = 1;
        if (le) begin
            if (imin(age, 2048) != HT) bad = 1;
            h = 0;
            m_t_fall = m_t;
            if (fe || m_armed) m_lines = 0;
            else begin
                m_lines++;
                if (m_lines == 1023) sat = 1;
            end
            m_armed = 0;
        end else begin
            h = imin(age, 2047);
            if (age == 2047) sat = 1;
            if (fe) m_armed = 1;
        end
        v = imin(m_lines, 1023);
        if (rise) begin
            if (h != HS) bad = 1;
        end else if (h == HS && hs == 0) bad = 1;
        viol = sat || (m_st != M_SEARCH && bad);
        if (viol) m_st = M_SEARCH;
        else if (fe) begin
            if (m_st == M_SEARCH) begin m_st = M_CHECK; m_good = 0; end
            else if (m_st == M_CHECK) begin
                m_good++;
                if (m_good == LF) m_st = M_LOCKED;
            end
        end
        if (viol && m_errs < 255) m_errs++;
        lk = (m_st == M_LOCKED);
        e.lk = lk;
        e.de = lk && h >= HAS && h < HAS + HA && v >= VAS && v < VAS + VA;
        e.x  = e.de ? h - HAS : 0;
        e.y  = e.de ? v - VAS : 0;
        e.r  = e.de ? r : 0;
        e.g  = e.de ? g : 0;
        e.b  = e.de ? b : 0;
        e.fs = lk && h == 0 && v == 0;
        e.er = viol;
        e.ec = m_errs;
        m_phs = hs; m_pvs = vs; m_t++;
        return e;
    endfunction

    task automatic check_zero_outputs(input string pfx);
        check({pfx, "_de"}, de, 0);
        check({pfx, "_locked"}, locked, 0);
        check({pfx, "_frame_start"}, frame_start, 0);
        check({pfx, "_err"}, err, 0);
        check({pfx, "_x"}, curr_x, 0);
        check({pfx, "_y"}, curr_y, 0);
        check({pfx, "_rgb"}, {red_out, gre_out, blu_out}, 0);
    endtask

    task automatic compare_outputs();
        exp_t e;
        e = exp_q.pop_front();
        check("de", de, e.de);
        check("curr_x", curr_x, e.x);
        check("curr_y", curr_y, e.y);
        check("red_out", red_out, e.r);
        check("gre_out", gre_out, e.g);
        check("blu_out", blu_out, e.b);
        check("locked", locked, e.lk);
        check("frame_start", frame_start, e.fs);
        check("err", err, e.er);
`ifdef VGA_RX_ERR_CNT_EN
        check("err_count", err_count, e.ec);
`endif
        if (de) de_count++;
        if (frame_start) fs_count++;
    endtask

    task automatic start_reset_window();
        model_reset();
        exp_q.delete();
        exp_q.push_back(idle_exp());
        exp_q.push_back(idle_exp());
    endtask

    task automatic cycle(input logic hs, input logic vs);
        exp_t e;
        logic [3:0] r, g, b;
        @(negedge clk);
        rst_n = 1'b1;
        compare_outputs();
        r = 4'($urandom); g = 4'($urandom); b = 4'($urandom);
        hsync_in = hs; vsync_in = vs; red_in = r; gre_in = g; blu_in = b;
        e = model_step(int'(hs), int'(vs), int'(r), int'(g), int'(b));
        exp_q.push_back(e);
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("midreset");
        start_reset_window();
    endtask

    task automatic gen_frame(input int nlines, input int short_line, input int wide_line,
                             input int rst_line, input int rst_h);
        for (int ln = 0; ln < nlines; ln++) begin
            int len;
            int sw;
            len = (ln == short_line) ? HT - 1 : HT;
            sw  = (ln == wide_line) ? HS + 1 : HS;
            for (int h = 0; h < len; h++) begin
                cycle(logic'(h >= sw), logic'(ln < 3));
                if (ln == rst_line && h == rst_h) async_reset();
            end
        end
    endtask

    task automatic clean_frames(input int n);
        for (int i = 0; i < n; i++) gen_frame(VT, -1, -1, -1, -1);
    endtask

    initial begin
        start_reset_window();
        #3 check_zero_outputs("reset");

        clean_frames(4);
        check("locked_after_clean", locked, 1);
        de_count = 0; fs_count = 0;
        clean_frames(1);
        check("de_cycles_per_frame", de_count, HA * VA);
        check("frame_starts_per_frame", fs_count, 1);

        gen_frame(VT, int'($urandom_range(0, VT - 1)), -1, -1, -1);
        clean_frames(4);

        for (int i = 0; i < 3000; i++) cycle(1'b1, 1'b0);
        check("locked_after_hold", locked, 0);
        clean_frames(4);

        gen_frame(VT + 1, -1, -1, -1, -1);
        clean_frames(4);

        gen_frame(VT, -1, int'($urandom_range(0, VT - 1)), -1, -1);
        clean_frames(3);

        gen_frame(VT, -1, -1, int'($urandom_range(VAS, VAS + VA - 1)),
                  int'($urandom_range(HAS, HAS + HA - 1)));
        clean_frames(4);
        check("locked_at_end", locked, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
